// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand forwarding, ALU/branch/address logic and a 32-cycle shift-add multiplier
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imm_in            sign-extended immediate from decode
//   val_rs_in/rt_in   register-file operands
//   rwd_in            destination register (0 = no writeback)
//   opcode_in         decoded opcode
//   rs_fwd/rt_fwd     operand source select: 1 = own result, 2 = memory stage, else register file
//   from_mem_in       result leaving the memory stage
//   alu_res_out       registered ALU result / memory address
//   val_rt_out        registered forwarded store data
//   rwd_out           registered destination register
//   opcode_out        registered opcode
//   zero_out          registered BEQ equality flag
//   busy_out          combinational freeze request while a multiply runs
module ex_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imm_in,
  input  logic [31:0] val_rs_in,
  input  logic [31:0] val_rt_in,
  input  logic [4:0]  rwd_in,
  input  logic [5:0]  opcode_in,
  input  logic [2:0]  rs_fwd,
  input  logic [2:0]  rt_fwd,
  input  logic [31:0] from_mem_in,
  output logic [31:0] alu_res_out,
  output logic [31:0] val_rt_out,
  output logic [4:0]  rwd_out,
  output logic [5:0]  opcode_out,
  output logic        zero_out,
  output logic        busy_out
);
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_SLT  = 6'd5;
  localparam logic [5:0] OP_LDW  = 6'd6;
  localparam logic [5:0] OP_SDW  = 6'd7;
  localparam logic [5:0] OP_BEQ  = 6'd8;
  localparam logic [5:0] OP_JUMP = 6'd9;
  localparam logic [5:0] OP_MUL  = 6'd10;
  localparam int CW = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [31:0]   op_a, rt_val, op_b, alu_val, result;
  logic [31:0]   mcand, mplier, prod;
  logic [CW-1:0] cnt;
  logic          mul_start;

  always_comb begin
    op_a   = rs_fwd == 3'd1 ? alu_res_out : rs_fwd == 3'd2 ? from_mem_in : val_rs_in;
    rt_val = rt_fwd == 3'd1 ? alu_res_out : rt_fwd == 3'd2 ? from_mem_in : val_rt_in;
    op_b   = (opcode_in == OP_LDW || opcode_in == OP_SDW) ? imm_in : rt_val;
  end

  always_comb begin
    alu_val = 32'h0;
    case (opcode_in)
      OP_ADD, OP_LDW, OP_SDW: alu_val = op_a + op_b;
      OP_SUB, OP_BEQ:         alu_val = op_a - op_b;
      OP_AND:                 alu_val = op_a & op_b;
      OP_OR:                  alu_val = op_a | op_b;
      OP_SLT:                 alu_val = {31'h0, $signed(op_a) < $signed(op_b)};
      OP_JUMP:                alu_val = imm_in;
      default:                alu_val = 32'h0;
    endcase
    // the product only becomes valid in DONE; any other MUL cycle never loads
    result = state == DONE ? prod : alu_val;
  end

  assign mul_start = state == IDLE && opcode_in == OP_MUL;

  always_comb begin
    state_nxt = state;
    busy_out  = 1'b0;
    case (state)
      IDLE: begin
        busy_out  = mul_start;
        state_nxt = mul_start ? RUN : IDLE;
      end
      RUN: begin
        busy_out  = 1'b1;
        state_nxt = cnt == CW'(MUL_CYCLES - 1) ? DONE : RUN;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand  <= 32'h0;
      mplier <= 32'h0;
      prod   <= 32'h0;
      cnt    <= '0;
    end else if (mul_start) begin
      mcand  <= op_a;
      mplier <= op_b;
      prod   <= 32'h0;
      cnt    <= '0;
    end else if (state == RUN) begin
      prod   <= prod + (mplier[0] ? mcand : 32'h0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end

  // outputs hold while busy so forwarding from alu_res_out stays stable
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_res_out <= 32'h0;
      val_rt_out  <= 32'h0;
      rwd_out     <= 5'h0;
      opcode_out  <= 6'h0;
      zero_out    <= 1'b0;
    end else if (!busy_out) begin
      alu_res_out <= result;
      val_rt_out  <= rt_val;
      rwd_out     <= rwd_in;
      opcode_out  <= opcode_in;
      zero_out    <= opcode_in == OP_BEQ && op_a == op_b;
    end
endmodule
